// File: rtl/pcihellocore_gpio_port.sv
// Parametrised bidirectional GPIO port on an Avalon-MM slave: direction, synchronised
// readback, edge capture and masked irq. Define PCIHELLOCORE_GPIO_SETCLR_EN to add OUTSET/OUTCLR.
module pcihellocore_gpio_port #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'd17,
  parameter logic [31:0] RESET_DIR   = 32'hFFFF_FFFF,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
`ifdef PCIHELLOCORE_GPIO_SETCLR_EN
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
`endif

  logic                                  write;
  logic [DATA_WIDTH-1:0]                 wdata;
  logic                                  unused_writedata;
  logic [DATA_WIDTH-1:0]                 data_out;
  logic [DATA_WIDTH-1:0]                 dir;
  logic [DATA_WIDTH-1:0]                 mask;
  logic [DATA_WIDTH-1:0]                 edge_cap;
  logic [DATA_WIDTH-1:0]                 cap_clr;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                 in_sync;
  logic [DATA_WIDTH-1:0]                 prev;
  logic [DATA_WIDTH-1:0]                 rise;
  logic [DATA_WIDTH-1:0]                 fall;
  logic [DATA_WIDTH-1:0]                 edge_det;

  assign write            = chipselect & ~write_n;
  assign wdata            = writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // sync_q[0] samples the pin; the last stage is the metastability-safe copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev;
  assign fall    = ~in_sync & prev;

  always_comb begin
    edge_det = rise | fall;
    if (EDGE_TYPE == 0) begin
      edge_det = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_det = fall;
    end
  end

  assign cap_clr = (write && (address == ADDR_CAP)) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[DATA_WIDTH-1:0];
      dir      <= RESET_DIR[DATA_WIDTH-1:0];
      mask     <= '0;
      edge_cap <= '0;
    end else begin
      if (write) begin
        case (address)
          ADDR_DATA: data_out <= wdata;
          ADDR_DIR:  dir      <= wdata;
          ADDR_MASK: mask     <= wdata;
`ifdef PCIHELLOCORE_GPIO_SETCLR_EN
          ADDR_SET:  data_out <= data_out | wdata;
          ADDR_CLR:  data_out <= data_out & ~wdata;
`endif
          default: ;
        endcase
      end
      // A fresh edge wins over a simultaneous software clear of the same bit.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:  readdata[DATA_WIDTH-1:0] = dir;
      ADDR_MASK: readdata[DATA_WIDTH-1:0] = mask;
      ADDR_CAP:  readdata[DATA_WIDTH-1:0] = edge_cap;
      default:   readdata = '0;
    endcase
  end

  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = |(edge_cap & mask);

endmodule

// File: tb/tb_pcihellocore_gpio_port.sv
// Randomised self-checking bench for pcihellocore_gpio_port against a register/delay-line model.
`timescale 1ns/1ps
module tb_pcihellocore_gpio_port;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int ET = 0;
  localparam logic [W-1:0] RV = 8'h11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic [W-1:0]  out_port;
  logic [W-1:0]  oe;
  logic          irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcihellocore_gpio_port #(
    .DATA_WIDTH(W), .RESET_VALUE(32'd17), .RESET_DIR(32'hFFFF_FFFF),
    .EDGE_TYPE(ET), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  // Model: software-visible registers plus a history of pin samples (index 0 = newest).
  logic [W-1:0] m_data, m_dir, m_mask, m_cap;
  logic [W-1:0] m_pins [0:S];

  function automatic logic [W-1:0] m_events();
    logic [W-1:0] now_v, old_v;
    now_v = m_pins[S-1];
    old_v = m_pins[S];
    if (ET == 0) return now_v & ~old_v;
    if (ET == 1) return ~now_v & old_v;
    return now_v ^ old_v;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = (m_dir & m_data) | (~m_dir & m_pins[S-1]);
      3'd1: r[W-1:0] = m_dir;
      3'd2: r[W-1:0] = m_mask;
      3'd3: r[W-1:0] = m_cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= RV;
      m_dir  <= '1;
      m_mask <= '0;
      m_cap  <= '0;
      for (int i = 0; i <= S; i++) m_pins[i] <= '0;
    end else begin
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0))
               | m_events();
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[W-1:0];
          3'd1: m_dir  <= writedata[W-1:0];
          3'd2: m_mask <= writedata[W-1:0];
`ifdef PCIHELLOCORE_GPIO_SETCLR_EN
          3'd4: m_data <= m_data | writedata[W-1:0];
          3'd5: m_data <= m_data & ~writedata[W-1:0];
`endif
          default: ;
        endcase
      end
      m_pins[0] <= in_port;
      for (int i = 1; i <= S; i++) m_pins[i] <= m_pins[i-1];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    #1 v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v [8];
    exp_v = '{32'h11, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset_n = 1'b0;
    in_port = '0;
    tick(3);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), v);
      checks++;
      if (v !== exp_v[a]) begin
        failures++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, v, exp_v[a]);
      end
    end
    checks++;
    if (out_port !== 8'h11) begin failures++; $display("FAIL reset_out_port got=%h exp=11", out_port); end
    checks++;
    if (oe !== 8'hFF) begin failures++; $display("FAIL reset_oe got=%h exp=ff", oe); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_dir_readback();
    logic [31:0] v;
    bus_wr(3'd1, 32'h0F);
    in_port = 8'hA5;
    tick(3);
    bus_rd(3'd0, v);
    checks++;
    if (v !== 32'hA1) begin failures++; $display("FAIL dir_readback got=%h exp=a1", v); end
    checks++;
    if (oe !== 8'h0F) begin failures++; $display("FAIL dir_oe got=%h exp=0f", oe); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] v;
    in_port = 8'h00;
    tick(4);
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd2, 32'h04);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_idle got=%b exp=0", irq); end
    in_port = 8'h04;
    tick(S);
    bus_rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL edge_cap_early got=%h exp=0", v); end
    tick();
    bus_rd(3'd3, v);
    checks++;
    if (v !== 32'h04) begin failures++; $display("FAIL edge_cap_set got=%h exp=04", v); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_set got=%b exp=1", irq); end
    bus_wr(3'd3, 32'h04);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] v;
    in_port = 8'h01;
    tick(4);
    bus_rd(3'd3, v);
    checks++;
    if (v !== 32'h01) begin failures++; $display("FAIL collide_pre got=%h exp=01", v); end
    in_port = 8'h05;
    tick(S);
    bus_wr(3'd3, 32'h05);
    bus_rd(3'd3, v);
    checks++;
    if (v !== 32'h04) begin failures++; $display("FAIL collide_cap got=%h exp=04", v); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL collide_irq got=%b exp=1", irq); end
    bus_wr(3'd3, 32'hFF);
  endtask

  task automatic test_setclr();
    logic [31:0] v;
    logic [W-1:0] e1, e2;
`ifdef PCIHELLOCORE_GPIO_SETCLR_EN
    e1 = 8'h91; e2 = 8'h90;
`else
    e1 = 8'h11; e2 = 8'h11;
`endif
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd0, 32'h11);
    bus_wr(3'd4, 32'h80);
    checks++;
    if (out_port !== e1) begin failures++; $display("FAIL outset got=%h exp=%h", out_port, e1); end
    bus_rd(3'd4, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL outset_read got=%h exp=0", v); end
    bus_wr(3'd5, 32'h01);
    checks++;
    if (out_port !== e2) begin failures++; $display("FAIL outclr got=%h exp=%h", out_port, e2); end
    bus_rd(3'd5, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL outclr_read got=%h exp=0", v); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [2:0]  a;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) bus_wr(a, $urandom);
      else tick();
      a = 3'($urandom_range(0, 7));
      bus_rd(a, v);
      checks++;
      if (v !== m_read(a)) begin
        failures++;
        $display("FAIL rand_read it=%0d addr=%0d got=%h exp=%h", it, a, v, m_read(a));
      end
      checks++;
      if (out_port !== m_data || oe !== m_dir || irq !== |(m_cap & m_mask)) begin
        failures++;
        $display("FAIL rand_pins it=%0d out=%h/%h oe=%h/%h irq=%b/%b", it, out_port, m_data,
                 oe, m_dir, irq, |(m_cap & m_mask));
      end
    end
  endtask

  task automatic test_reset_artefact();
    logic [31:0] v;
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int c = 0; c < S + 2; c++) begin
      tick();
      bus_rd(3'd3, v);
      checks++;
      if (v !== m_read(3'd3)) begin
        failures++;
        $display("FAIL artefact_cycle c=%0d got=%h exp=%h", c, v, m_read(3'd3));
      end
    end
    checks++;
    if (v !== 32'hFF) begin failures++; $display("FAIL artefact_final got=%h exp=ff", v); end
    bus_wr(3'd0, 32'h3C);
    bus_wr(3'd1, 32'h00);
    bus_wr(3'd2, 32'hFF);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midreset_pre_irq got=%b exp=1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== RV || oe !== 8'hFF || irq !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pins out=%h oe=%h irq=%b exp 11/ff/0", out_port, oe, irq);
    end
    bus_rd(3'd3, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL midreset_cap got=%h exp=0", v); end
    bus_rd(3'd2, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL midreset_mask got=%h exp=0", v); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_dir_readback();
    test_edge_irq();
    test_w1c_collision();
    test_setclr();
    test_random();
    test_reset_artefact();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
